amp_enable_sequencer: RTL and testbench
=======================================

# amp_enable_sequencer

Staggers amplifier power-up across the motor channels of a QLA/DQLA board. When the host requests enable on several channels at once, only one channel at a time is allowed through. Successive enables are separated by a programmable gap, which limits inrush on the motor supply. The block sits between the per-channel host enable state and the `MotorChannelQLA` amp-enable path, and applies fault and watchdog disables immediately.

## Interface
- `NUM_MOT`, 4: number of motor channels (1..8).
- `PRESCALE`, 1024: clk cycles per gap tick (1024 at 49.152 MHz gives 20.83 us).
- `clk`  in  1  system clock (49.152 MHz).
- `reset`  in  1  asynchronous, active-high reset.
- `enable_req`  in  NUM_MOT  host-requested enable per channel (level, synchronous to clk).
- `fault`  in  NUM_MOT  per-channel safety disable (level; 1 forces the channel off).
- `wdog_timeout`  in  1  watchdog timeout; 1 forces all channels off.
- `gap_cnt`  in  8  gap between successive enables, in ticks.
- `amp_enable`  out  NUM_MOT  sequenced enable to the motor channels (registered).
- `grant`  out  1  one-cycle pulse coincident with each `amp_enable` rising edge.
- `grant_chan`  out  3  index of the most recently granted channel.
- `busy`  out  1  1 while in WAIT.

## Operation
- Per-channel pending: `pending[i] = enable_req[i] & ~fault[i] & ~amp_enable[i]`.
- FSM has two states: IDLE and WAIT.
- **IDLE**
  - If `pending != 0` and `wdog_timeout == 0`: select one pending channel `c` (see Configuration).
  - Register `amp_enable[c] <= 1`, `grant <= 1`, `grant_chan <= c`.
  - Latch `gap_cnt`, clear the prescaler and the tick counter, and go to WAIT.
- **WAIT**
  - Prescaler counts 0..PRESCALE-1. On wrap, the tick counter increments; it saturates at 255.
  - Exit to IDLE when tick counter == latched gap. A latched gap of 0 exits in the first WAIT cycle.
- **Drop rule (any state)**
  - `amp_enable[i] <= 0` on the next clk when `enable_req[i]==0` or `fault[i]==1`.
  - A drop does not abort WAIT. The gap still elapses.
- **Watchdog**
  - `wdog_timeout==1` clears all `amp_enable` and forces IDLE (WAIT aborted, counters cleared).
  - No grant is issued while it is asserted.
- **Priority and edge cases**
  - If a channel's fault and a grant of that channel occur in the same cycle, fault wins: no grant, no `grant` pulse.
  - Requests arriving during WAIT stay pending; they are served in selection order once IDLE is reached.
  - `gap_cnt` changes during WAIT have no effect until the next grant.
- **Reset values**
  - `amp_enable=0`, `grant=0`, `grant_chan=0`, `busy=0`, state IDLE.
  - Prescaler, tick counter and round-robin pointer are 0.
  - Reset mid-WAIT returns to these values immediately (asynchronous reset).

## Timing
- Grant latency: `pending` seen in IDLE at cycle t gives `amp_enable[c]`/`grant` high at t+1 and `busy` high at t+1.
- Spacing between consecutive grant edges, with the request pending throughout: exactly `gap*PRESCALE + 2` clk cycles. With gap=0 this is 2 cycles.
- `busy` falls exactly `gap*PRESCALE + 1` cycles after the grant edge.
- Disable latency: a `fault`, `enable_req` or `wdog_timeout` change at cycle t takes effect on `amp_enable` at t+1.
- `grant` is high for exactly one cycle per grant.

## Configuration
- Macro: `AMP_SEQ_RR_EN`.
- **Defined (round-robin):**
  - The selected channel is the first pending channel at or after `(last grant_chan + 1) mod NUM_MOT`.
  - The pointer updates on every grant.
- **Undefined (fixed priority):**
  - The lowest-index pending channel is always selected.
  - The pointer logic is not built.
- All other behaviour is identical in both builds.

## Test plan
- **Stagger:** PRESCALE=4, gap=3, `enable_req` 0000→1111 at cycle 10.
  - Grants ch0,1,2,3 at cycles 11, 25, 39, 53 (14-cycle spacing).
  - `busy` falls 13 cycles after each grant.
- **Zero gap:** gap=0, `enable_req`=0111.
  - Grants ch0,1,2 at 2-cycle spacing; `busy` is high one cycle each.
- **Fault mid-sequence:** gap=3, all requested; assert `fault[1]` during the first WAIT.
  - ch1 is never enabled; ch2 follows ch0 by 14 cycles.
  - Raising `fault[0]` clears `amp_enable[0]` next cycle and does not shorten WAIT.
- **Watchdog:** assert `wdog_timeout` during WAIT with two channels enabled.
  - All `amp_enable` are 0 next cycle and `busy=0`.
  - No grants while it is high; sequencing restarts from ch0/pointer after it is released.
- **Priority build check:** ch0 enabled and dropped, then `enable_req` = 0101 pending.
  - With `AMP_SEQ_RR_EN` after last grant ch0: ch2 is granted first.
  - Without the macro: ch0 is granted first.
- **Async reset:** assert `reset` mid-WAIT with `amp_enable`=0011.
  - All outputs are 0 without waiting for a clk edge.
  - After release, the re-requested channels sequence from IDLE normally.

Source files
------------

// File: rtl/amp_enable_sequencer.sv
// ============================================================================
// amp_enable_sequencer
//
// Purpose:
//   Staggers amplifier power-up across the motor channels. When several
//   channels request enable together, one channel is granted at a time.
//   After each grant the block waits gap_cnt ticks before the next grant,
//   where one tick is PRESCALE clk cycles. This spacing limits inrush current
//   on the motor supply. Fault, request-drop and watchdog disables bypass the
//   sequencing and take effect on the next clk.
//
// Configuration macro:
//   AMP_SEQ_RR_EN  defined   -> round-robin channel selection, starting after
//                               the most recently granted channel.
//                  undefined -> fixed priority, lowest index wins.
//
// Parameters:
//   NUM_MOT   number of motor channels (1..8)
//   PRESCALE  clk cycles per gap tick
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous, active-high reset
//   enable_req    in   [NUM_MOT] host-requested enable per channel (level)
//   fault         in   [NUM_MOT] per-channel safety disable (level)
//   wdog_timeout  in   watchdog timeout, forces all channels off
//   gap_cnt       in   [8] gap between successive enables, in ticks
//   amp_enable    out  [NUM_MOT] registered sequenced enable per channel
//   grant         out  one-cycle pulse on each amp_enable rising edge
//   grant_chan    out  [3] index of the most recently granted channel
//   busy          out  high while the inter-grant gap is running (WAIT)
// ============================================================================
module amp_enable_sequencer #(
    parameter int NUM_MOT  = 4,
    parameter int PRESCALE = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_MOT-1:0] enable_req,
    input  logic [NUM_MOT-1:0] fault,
    input  logic               wdog_timeout,
    input  logic [7:0]         gap_cnt,
    output logic [NUM_MOT-1:0] amp_enable,
    output logic               grant,
    output logic [2:0]         grant_chan,
    output logic               busy
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_MOT-1:0] amp_q, amp_d;
    logic               grant_q, grant_d;
    logic [2:0]         chan_q, chan_d;
    logic [PW-1:0]      pre_q, pre_d;
    logic [7:0]         tick_q, tick_d;
    logic [7:0]         gap_q, gap_d;

    // A faulted or already-enabled channel is never a grant candidate, so a
    // fault that coincides with selection simply removes that channel.
    logic [NUM_MOT-1:0] pending;
    logic               sel_valid;
    logic [2:0]         sel_chan;

    assign pending = enable_req & ~fault & ~amp_q;

`ifdef AMP_SEQ_RR_EN
    // ptr_q holds the first channel to consider: one past the last grant.
    logic [2:0]           ptr_q, ptr_d;
    logic [2*NUM_MOT-1:0] pend_dbl;
    logic [NUM_MOT-1:0]   pend_rot;
    int                   sel_sum;

    // Rotate pending so the pointer lands at bit 0, find the lowest set bit,
    // then map the offset back to an absolute channel index.
    always_comb begin
        pend_dbl  = {pending, pending} >> ptr_q;
        pend_rot  = pend_dbl[NUM_MOT-1:0];
        sel_valid = 1'b0;
        sel_chan  = 3'd0;
        sel_sum   = 0;
        for (int i = NUM_MOT - 1; i >= 0; i--) begin
            if (pend_rot[i]) begin
                sel_valid = 1'b1;
                sel_sum   = int'(ptr_q) + i;
                if (sel_sum >= NUM_MOT) begin
                    sel_sum = sel_sum - NUM_MOT;
                end
                sel_chan = 3'(sel_sum);
            end
        end
    end
`else
    // Scanning downward leaves the lowest-index pending channel selected.
    always_comb begin
        sel_valid = 1'b0;
        sel_chan  = 3'd0;
        for (int i = NUM_MOT - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_valid = 1'b1;
                sel_chan  = 3'(i);
            end
        end
    end
`endif

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        // Drop rule applies in every state: a request drop or fault clears
        // the enable on the next clk without disturbing the gap timer.
        amp_d   = amp_q & enable_req & ~fault;
        grant_d = 1'b0;
        chan_d  = chan_q;
        pre_d   = pre_q;
        tick_d  = tick_q;
        gap_d   = gap_q;
`ifdef AMP_SEQ_RR_EN
        ptr_d   = ptr_q;
`endif

        if (wdog_timeout) begin
            amp_d   = '0;
            state_d = ST_IDLE;
            pre_d   = '0;
            tick_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_valid) begin
                        amp_d   = amp_d | (NUM_MOT'(1) << sel_chan);
                        grant_d = 1'b1;
                        chan_d  = sel_chan;
                        gap_d   = gap_cnt;
                        pre_d   = '0;
                        tick_d  = '0;
                        state_d = ST_WAIT;
`ifdef AMP_SEQ_RR_EN
                        if (sel_chan == 3'(NUM_MOT - 1)) begin
                            ptr_d = 3'd0;
                        end else begin
                            ptr_d = sel_chan + 3'd1;
                        end
`endif
                    end
                end
                ST_WAIT: begin
                    // Comparing before counting lets a gap of 0 leave on the
                    // first WAIT cycle.
                    if (tick_q == gap_q) begin
                        state_d = ST_IDLE;
                    end else if (pre_q == PW'(PRESCALE - 1)) begin
                        pre_d = '0;
                        if (tick_q != 8'hFF) begin
                            tick_d = tick_q + 8'd1;
                        end
                    end else begin
                        pre_d = pre_q + PW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    // NOTE: all control state is reset, including counters and pointer, so a
    // reset in the middle of WAIT leaves no stale timing behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            amp_q   <= '0;
            grant_q <= 1'b0;
            chan_q  <= 3'd0;
            pre_q   <= '0;
            tick_q  <= 8'd0;
            gap_q   <= 8'd0;
`ifdef AMP_SEQ_RR_EN
            ptr_q   <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            amp_q   <= amp_d;
            grant_q <= grant_d;
            chan_q  <= chan_d;
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            gap_q   <= gap_d;
`ifdef AMP_SEQ_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign amp_enable = amp_q;
    assign grant      = grant_q;
    assign grant_chan = chan_q;
    assign busy       = (state_q == ST_WAIT);

endmodule

// File: tb/tb_amp_enable_sequencer.sv
// ============================================================================
// tb_amp_enable_sequencer
//
// Directed bench for amp_enable_sequencer with NUM_MOT=4, PRESCALE=4. With
// gap=3 a grant-to-grant spacing is 3*4+2 = 14 cycles and busy falls 13
// cycles after each grant. Inputs are driven and outputs sampled 1 time unit
// after the rising clk edge. Expected values depend on AMP_SEQ_RR_EN only
// where channel selection order differs between builds.
// ============================================================================
module tb_amp_enable_sequencer;

    localparam int NUM_MOT  = 4;
    localparam int PRESCALE = 4;
    localparam int LIMIT    = 300;

    logic               clk;
    logic               reset;
    logic [NUM_MOT-1:0] enable_req;
    logic [NUM_MOT-1:0] fault;
    logic               wdog_timeout;
    logic [7:0]         gap_cnt;
    logic [NUM_MOT-1:0] amp_enable;
    logic               grant;
    logic [2:0]         grant_chan;
    logic               busy;

    int n_checks = 0;
    int n_pass   = 0;
    int busy_n;
    int grant_n;

    amp_enable_sequencer #(
        .NUM_MOT  (NUM_MOT),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable_req   (enable_req),
        .fault        (fault),
        .wdog_timeout (wdog_timeout),
        .gap_cnt      (gap_cnt),
        .amp_enable   (amp_enable),
        .grant        (grant),
        .grant_chan   (grant_chan),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Counts cycles until the next grant pulse (bounded); records the first
    // cycle at which busy reads low.
    task automatic measure(output int b_n, output int g_n);
        b_n = -1;
        g_n = 0;
        do begin
            tick();
            g_n++;
            if (b_n < 0 && !busy) b_n = g_n;
        end while (!grant && g_n < LIMIT);
    endtask

    // Asynchronous reset pulse between clock edges; clears all inputs.
    task automatic do_reset();
        reset        = 1'b1;
        enable_req   = '0;
        fault        = '0;
        wdog_timeout = 1'b0;
        #2;
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset        = 1'b1;
        enable_req   = '0;
        fault        = '0;
        wdog_timeout = 1'b0;
        gap_cnt      = 8'd3;
        #12;
        check("rst_amp",   amp_enable, 4'b0000);
        check("rst_grant", grant,      1'b0);
        check("rst_chan",  grant_chan, 3'd0);
        check("rst_busy",  busy,       1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ---------------- Stagger, gap=3 ----------------
        enable_req = 4'b1111;
        tick();
        check("stag_g0",      grant,      1'b1);
        check("stag_g0_chan", grant_chan, 3'd0);
        check("stag_g0_amp",  amp_enable, 4'b0001);
        check("stag_g0_busy", busy,       1'b1);
        measure(busy_n, grant_n);
        check("stag_busy0",   busy_n,     13);
        check("stag_space01", grant_n,    14);
        check("stag_g1_chan", grant_chan, 3'd1);
        check("stag_g1_amp",  amp_enable, 4'b0011);
        // gap_cnt changed during WAIT must not alter the running gap.
        gap_cnt = 8'd9;
        ticks(5);
        gap_cnt = 8'd3;
        measure(busy_n, grant_n);
        check("stag_busy1",   busy_n,     8);
        check("stag_space12", grant_n,    9);
        check("stag_g2_chan", grant_chan, 3'd2);
        check("stag_g2_amp",  amp_enable, 4'b0111);
        measure(busy_n, grant_n);
        check("stag_busy2",   busy_n,     13);
        check("stag_space23", grant_n,    14);
        check("stag_g3_chan", grant_chan, 3'd3);
        check("stag_g3_amp",  amp_enable, 4'b1111);
        ticks(12);
        check("stag_busy3_hi", busy, 1'b1);
        tick();
        check("stag_busy3_lo", busy, 1'b0);
        tick();
        check("stag_no_more",  grant, 1'b0);
        check("stag_amp_hold", amp_enable, 4'b1111);

        // ---------------- Zero gap ----------------
        do_reset();
        gap_cnt    = 8'd0;
        enable_req = 4'b0111;
        tick();
        check("zg_g0",      grant,      1'b1);
        check("zg_g0_chan", grant_chan, 3'd0);
        check("zg_g0_amp",  amp_enable, 4'b0001);
        check("zg_g0_busy", busy,       1'b1);
        tick();
        check("zg_pulse0",  grant, 1'b0);
        check("zg_busy0",   busy,  1'b0);
        tick();
        check("zg_g1",      grant,      1'b1);
        check("zg_g1_chan", grant_chan, 3'd1);
        check("zg_g1_amp",  amp_enable, 4'b0011);
        tick();
        check("zg_busy1",   busy, 1'b0);
        tick();
        check("zg_g2",      grant,      1'b1);
        check("zg_g2_chan", grant_chan, 3'd2);
        check("zg_g2_amp",  amp_enable, 4'b0111);
        ticks(2);
        check("zg_idle",    grant, 1'b0);

        // ---------------- Fault mid-sequence ----------------
        do_reset();
        gap_cnt    = 8'd3;
        enable_req = 4'b1111;
        tick();
        check("flt_g0_chan", grant_chan, 3'd0);
        fault = 4'b0010;
        measure(busy_n, grant_n);
        check("flt_busy0",   busy_n,     13);
        check("flt_space02", grant_n,    14);
        check("flt_g2_chan", grant_chan, 3'd2);
        check("flt_g2_amp",  amp_enable, 4'b0101);
        fault = 4'b0011;
        tick();
        check("flt_drop0",   amp_enable, 4'b0100);
        check("flt_busy_on", busy,       1'b1);
        measure(busy_n, grant_n);
        check("flt_busy2",   busy_n,     12);
        check("flt_space23", grant_n,    13);
        check("flt_g3_chan", grant_chan, 3'd3);
        check("flt_g3_amp",  amp_enable, 4'b1100);

        // ---------------- Watchdog ----------------
        do_reset();
        gap_cnt    = 8'd3;
        enable_req = 4'b1111;
        tick();
        check("wd_g0_chan", grant_chan, 3'd0);
        measure(busy_n, grant_n);
        check("wd_g1_chan", grant_chan, 3'd1);
        check("wd_g1_amp",  amp_enable, 4'b0011);
        ticks(3);
        check("wd_busy_pre", busy, 1'b1);
        wdog_timeout = 1'b1;
        tick();
        check("wd_amp_off", amp_enable, 4'b0000);
        check("wd_busy",    busy,       1'b0);
        check("wd_grant",   grant,      1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("wd_hold_grant", grant,      1'b0);
            check("wd_hold_amp",   amp_enable, 4'b0000);
        end
        wdog_timeout = 1'b0;
        tick();
        check("wd_restart", grant, 1'b1);
`ifdef AMP_SEQ_RR_EN
        check("wd_restart_chan", grant_chan, 3'd2);
        check("wd_restart_amp",  amp_enable, 4'b0100);
`else
        check("wd_restart_chan", grant_chan, 3'd0);
        check("wd_restart_amp",  amp_enable, 4'b0001);
`endif

        // ---------------- Selection order ----------------
        do_reset();
        gap_cnt    = 8'd0;
        enable_req = 4'b0001;
        tick();
        check("pri_g0_chan", grant_chan, 3'd0);
        enable_req = 4'b0000;
        tick();
        check("pri_drop",    amp_enable, 4'b0000);
        check("pri_idle",    busy,       1'b0);
        enable_req = 4'b0101;
        tick();
        check("pri_grant",   grant, 1'b1);
`ifdef AMP_SEQ_RR_EN
        check("pri_chan",    grant_chan, 3'd2);
        check("pri_amp",     amp_enable, 4'b0100);
`else
        check("pri_chan",    grant_chan, 3'd0);
        check("pri_amp",     amp_enable, 4'b0001);
`endif

        // ---------------- Asynchronous reset mid-WAIT ----------------
        do_reset();
        gap_cnt    = 8'd3;
        enable_req = 4'b0011;
        tick();
        check("ar_g0_chan", grant_chan, 3'd0);
        measure(busy_n, grant_n);
        check("ar_g1_chan", grant_chan, 3'd1);
        check("ar_g1_amp",  amp_enable, 4'b0011);
        ticks(2);
        #2;
        reset = 1'b1;
        #1;
        check("ar_amp",   amp_enable, 4'b0000);
        check("ar_busy",  busy,       1'b0);
        check("ar_grant", grant,      1'b0);
        check("ar_chan",  grant_chan, 3'd0);
        #1;
        reset = 1'b0;
        tick();
        check("ar_re_g0",      grant,      1'b1);
        check("ar_re_g0_chan", grant_chan, 3'd0);
        check("ar_re_g0_amp",  amp_enable, 4'b0001);
        measure(busy_n, grant_n);
        check("ar_re_busy",    busy_n,     13);
        check("ar_re_space",   grant_n,    14);
        check("ar_re_g1_chan", grant_chan, 3'd1);
        check("ar_re_g1_amp",  amp_enable, 4'b0011);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
